iir_biquad_stream: RTL and testbench

Synthesizable second-order IIR section (Direct Form I biquad) that consumes 16-bit samples over a valid/ready stream and produces filtered 16-bit samples on a second valid/ready stream. It is the hardware end of the file-driven sample/coefficient flow used by the IIR benches: coefficients arrive over a register-write port, samples stream in, and results stream out. A single time-multiplexed multiplier keeps area low at the cost of throughput.

---
 rtl/iir_pkg.sv | 24 ++
 rtl/iir_mac.sv | 35 +++
 rtl/iir_biquad_stream.sv | 167 ++++++++++++++++
 tb/tb_iir_biquad_stream.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared constants and FSM state type for the time-multiplexed biquad.
package iir_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_COEF_W  = 16;
    localparam int DEF_ACC_W   = 40;
    localparam int FRAC_BITS   = 14;
    localparam int ROUND_CONST = 1 << (FRAC_BITS - 1);

    // Coefficient register indices double as the MAC tap sequence
    localparam logic [2:0] IDX_B0 = 3'd0;
    localparam logic [2:0] IDX_B1 = 3'd1;
    localparam logic [2:0] IDX_B2 = 3'd2;
    localparam logic [2:0] IDX_A1 = 3'd3;
    localparam logic [2:0] IDX_A2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_RND,
        ST_OUT
    } state_t;

endpackage

// File: rtl/iir_mac.sv
// Signed coefficient x sample multiplier feeding an add/subtract accumulator.
module iir_mac #(
    parameter int COEF_W = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = COEF_W + DATA_W;

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;

    assign product     = coef * sample;
    assign product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - product_ext) : (acc + product_ext);
        end
    end

endmodule

// File: rtl/iir_biquad_stream.sv
// Direct Form I biquad over valid/ready streams using one shared multiplier.
// Define IIR_SAT_EN to saturate the output; otherwise it wraps to DATA_W bits.
module iir_biquad_stream
    import iir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    input  logic                     coef_we,
    input  logic [2:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_busy
);

    localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(ROUND_CONST);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    state_t state;
    logic [2:0] tap;

    logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;
    logic signed [DATA_W-1:0] x0, x1, x2, y1, y2;

    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_sample;
    logic                     mac_sub;
    logic                     mac_clear;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;

    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] result;

    assign s_ready   = (state == ST_IDLE);
    assign coef_busy = (state != ST_IDLE);
    assign mac_clear = (state == ST_IDLE) && s_valid;
    assign mac_en    = (state == ST_MAC);

    // Feedback taps are subtracted, so the a-terms drive the MAC in subtract mode
    always_comb begin
        mac_coef   = '0;
        mac_sample = '0;
        mac_sub    = 1'b0;
        case (tap)
            IDX_B0: begin mac_coef = b0; mac_sample = x0; end
            IDX_B1: begin mac_coef = b1; mac_sample = x1; end
            IDX_B2: begin mac_coef = b2; mac_sample = x2; end
            IDX_A1: begin mac_coef = a1; mac_sample = y1; mac_sub = 1'b1; end
            IDX_A2: begin mac_coef = a2; mac_sample = y2; mac_sub = 1'b1; end
            default: ;
        endcase
    end

    iir_mac #(
        .COEF_W (COEF_W),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .en     (mac_en),
        .sub    (mac_sub),
        .coef   (mac_coef),
        .sample (mac_sample),
        .acc    (acc)
    );

    always_comb begin
        rounded = acc + ROUND_K;
        shifted = rounded >>> FRAC_BITS;
`ifdef IIR_SAT_EN
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
`else
        result = shifted[DATA_W-1:0];
`endif
    end

`ifndef IIR_SAT_EN
    logic unused_hi;
    assign unused_hi = ^{shifted[ACC_W-1:DATA_W], SAT_MAX, SAT_MIN};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tap     <= '0;
            b0      <= '0;
            b1      <= '0;
            b2      <= '0;
            a1      <= '0;
            a2      <= '0;
            x0      <= '0;
            x1      <= '0;
            x2      <= '0;
            y1      <= '0;
            y2      <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            // A write in the accepting cycle lands before the first MAC tap reads it
            if (coef_we && state == ST_IDLE) begin
                case (coef_addr)
                    IDX_B0:  b0 <= coef_data;
                    IDX_B1:  b1 <= coef_data;
                    IDX_B2:  b2 <= coef_data;
                    IDX_A1:  a1 <= coef_data;
                    IDX_A2:  a2 <= coef_data;
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        x0    <= s_data;
                        tap   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (tap == IDX_A2) begin
                        state <= ST_RND;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                ST_RND: begin
                    m_data  <= result;
                    m_valid <= 1'b1;
                    x2      <= x1;
                    x1      <= x0;
                    y2      <= y1;
                    y1      <= result;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_stream.sv
// Self-checking bench for iir_biquad_stream against an arithmetic reference model.
// Honours IIR_SAT_EN the same way the design does.
module tb_iir_biquad_stream;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_data;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               coef_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: coefficient values and past inputs/outputs as plain integers
    int coef_m [5];
    int xh1, xh2, yh1, yh2;

    iir_biquad_stream dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_busy (coef_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) coef_m[i] = 0;
        xh1 = 0; xh2 = 0; yh1 = 0; yh2 = 0;
    endtask

    function automatic int model_step(input int x);
        longint sum;
        longint r;
        longint lo;
        int y;
        sum = longint'(coef_m[0]) * x + longint'(coef_m[1]) * xh1 + longint'(coef_m[2]) * xh2
            - longint'(coef_m[3]) * yh1 - longint'(coef_m[4]) * yh2;
        // Round half up, then floor-divide by 2^14
        r = (sum + 8192) >>> 14;
`ifdef IIR_SAT_EN
        if (r > 32767) y = 32767;
        else if (r < -32768) y = -32768;
        else y = int'(r);
`else
        lo = r & 64'hFFFF;
        y = (lo >= 32768) ? int'(lo - 65536) : int'(lo);
`endif
        xh2 = xh1; xh1 = x;
        yh2 = yh1; yh1 = y;
        return y;
    endfunction

    task automatic writeCoef(input logic [2:0] addr, input int data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data[15:0];
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < 3'd5) coef_m[addr] = data;
    endtask

    // One full sample: accept, latency check, optional backpressure, handshake
    task automatic applyStimulus(input int x, input int hold, input bit busy_write, output int y_out);
        int waited;
        int lat;
        int y_exp;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = x[15:0];
        waited  = 0;
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        y_exp = model_step(x);
        @(negedge clk);
        s_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 50) begin
            if (busy_write && lat == 1) begin
                coef_we   = 1'b1;
                coef_addr = 3'd0;
                coef_data = 16'sd1234;
            end else begin
                coef_we = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        coef_we = 1'b0;
        checkOutput("latency", lat, 6);
        checkOutput("out_value", longint'(m_data), y_exp);
        y_out = int'(m_data);
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            s_data  = 16'(int'($urandom_range(0, 65535)));
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_valid", longint'(m_valid), 1);
            checkOutput("bp_data", longint'(m_data), y_exp);
            checkOutput("bp_sready", longint'(s_ready), 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        checkOutput("post_valid", longint'(m_valid), 0);
        checkOutput("post_sready", longint'(s_ready), 1);
    endtask

    // Start a sample, then pull reset while the MAC is on tap 2
    task automatic resetMidMac(input int x);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = x[15:0];
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("rst_mvalid", longint'(m_valid), 0);
        end
        checkOutput("rst_sready", longint'(s_ready), 1);
        checkOutput("rst_busy", longint'(coef_busy), 0);
        checkOutput("rst_mdata", longint'(m_data), 0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int y;
        int samp;
        int addr;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_sready", longint'(s_ready), 1);
        checkOutput("reset_mvalid", longint'(m_valid), 0);
        checkOutput("reset_mdata", longint'(m_data), 0);
        checkOutput("reset_busy", longint'(coef_busy), 0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(500, 0, 1'b0, y);
        checkOutput("unwritten_coefs", y, 0);

        writeCoef(3'd0, 16384);
        applyStimulus(1000, 0, 1'b0, y);
        checkOutput("pass_pos", y, 1000);
        applyStimulus(-1000, 0, 1'b0, y);
        checkOutput("pass_neg", y, -1000);
        applyStimulus(32767, 0, 1'b0, y);
        checkOutput("pass_max", y, 32767);

        applyStimulus(0, 0, 1'b0, y);
        applyStimulus(0, 0, 1'b0, y);
        writeCoef(3'd3, -8192);
        applyStimulus(16384, 0, 1'b0, y);
        checkOutput("decay_0", y, 16384);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1'b0, y);
            checkOutput("decay_k", y, 16384 >> k);
        end

        writeCoef(3'd3, 0);
        applyStimulus(0, 0, 1'b0, y);
        applyStimulus(0, 0, 1'b0, y);
        writeCoef(3'd0, 32767);
        applyStimulus(30000, 0, 1'b0, y);
`ifdef IIR_SAT_EN
        checkOutput("overflow", y, 32767);
`else
        checkOutput("overflow", y, -5538);
`endif

        writeCoef(3'd0, 16384);
        applyStimulus(1234, 10, 1'b0, y);
        checkOutput("backpressure", y, 1234);

        applyStimulus(2000, 0, 1'b1, y);
        checkOutput("busy_write_same", y, 2000);
        applyStimulus(-3000, 0, 1'b0, y);
        checkOutput("busy_write_next", y, -3000);

        resetMidMac(4000);
        writeCoef(3'd1, 16384);
        writeCoef(3'd2, 16384);
        writeCoef(3'd3, 8192);
        applyStimulus(700, 0, 1'b0, y);
        checkOutput("after_reset_hist", y, 0);
        applyStimulus(0, 0, 1'b0, y);
        checkOutput("after_reset_x1", y, 700);

        for (int n = 0; n < 25; n++) begin
            if (n % 5 == 0) begin
                for (int w = 0; w < 3; w++) begin
                    addr = int'($urandom_range(0, 7));
                    writeCoef(3'(addr), int'($urandom_range(0, 65535)) - 32768);
                end
            end
            samp = int'($urandom_range(0, 65535)) - 32768;
            applyStimulus(samp, int'($urandom_range(0, 3)), 1'b0, y);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
